// File: rtl/ram_stream_reader.sv
// Streams a burst of words from a synchronous-read RAM into a 3-entry output buffer
// with valid/ready handshake; reads are credit-limited so the buffer can never overflow.
module ram_stream_reader #(
    parameter int ADDR_LEN = 6,
    parameter int DATA_LEN = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    input  logic [ADDR_LEN+1:0]   base_addr,
    input  logic [ADDR_LEN+2:0]   length,
    output logic [ADDR_LEN+1:0]   rd_addr,
    input  logic [DATA_LEN-1:0]   ram_q,
    output logic [DATA_LEN-1:0]   out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done
);

    localparam int AW = ADDR_LEN + 2;
    localparam int LW = ADDR_LEN + 3;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [AW-1:0]         r_rd_addr;
    logic [LW-1:0]         r_issue_left;
    logic [LW-1:0]         r_xfer_left;
    logic                  r_v1;
    logic                  r_v2;
    logic [1:0]            r_count;
    logic [DATA_LEN-1:0]   r_buf [3];
    logic [DATA_LEN-1:0]   w_buf_next [3];

    logic                  w_xfer;
    logic                  w_issue;
    logic [2:0]            w_committed;
    logic [1:0]            w_wr_idx;
    logic [1:0]            w_count_next;

    // Buffered plus in-flight words after this edge's transfer; a new read may take one more slot.
    assign w_xfer       = (r_count != 2'd0) && out_ready;
    assign w_committed  = 3'(r_count) + 3'(r_v1) + 3'(r_v2) - 3'(w_xfer);
    assign w_wr_idx     = r_count - 2'(w_xfer);
    assign w_count_next = r_count + 2'(r_v2) - 2'(w_xfer);

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        w_issue      = 1'b0;
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        w_issue      = 1'b1;
                        w_state_next = FETCH;
                    end else begin
                        w_state_next = DONE;
                    end
                end
            end
            FETCH: begin
                w_issue = (r_issue_left != '0) && (w_committed < 3'd3);
                if ((r_issue_left - LW'(w_issue)) == '0)
                    w_state_next = DRAIN;
            end
            DRAIN: begin
                if (w_xfer && (r_xfer_left == LW'(1)))
                    w_state_next = DONE;
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_buf_next = r_buf;
        if (w_xfer) begin
            w_buf_next[0] = r_buf[1];
            w_buf_next[1] = r_buf[2];
        end
        if (r_v2)
            w_buf_next[w_wr_idx] = ram_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= IDLE;
            r_rd_addr    <= '0;
            r_issue_left <= '0;
            r_xfer_left  <= '0;
            r_v1         <= 1'b0;
            r_v2         <= 1'b0;
            r_count      <= 2'd0;
            // NOTE: the buffer is only three registers and its head drives out_data, so it is reset too.
            for (int i = 0; i < 3; i++)
                r_buf[i] <= '0;
        end else begin
            r_state <= w_state_next;
            r_v1    <= w_issue;
            r_v2    <= r_v1;
            r_count <= w_count_next;
            r_buf   <= w_buf_next;
            if (w_issue)
                r_rd_addr <= (r_state == IDLE) ? base_addr : r_rd_addr + AW'(1);
            if (r_state == IDLE) begin
                if (start && (length != '0)) begin
                    r_issue_left <= length - LW'(1);
                    r_xfer_left  <= length;
                end
            end else begin
                if (w_issue)
                    r_issue_left <= r_issue_left - LW'(1);
                if (w_xfer)
                    r_xfer_left <= r_xfer_left - LW'(1);
            end
        end
    end

    assign rd_addr   = r_rd_addr;
    assign out_data  = r_buf[0];
    assign out_valid = (r_count != 2'd0);
    assign busy      = (r_state == FETCH) || (r_state == DRAIN);
    assign done      = (r_state == DONE);

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader: latency, wrap, back-pressure, empty burst,
// reset abort, start-while-busy and a full-address-space burst against a mem[i]=i RAM.
module tb_ram_stream_reader;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] base_addr;
    logic [8:0] length;
    logic [7:0] rd_addr;
    logic [7:0] ram_q;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       done;

    logic [7:0] mem [256];
    int         checks;
    int         errors;
    int         done_cnt;
    int         exp_done;
    logic [7:0] got [$];

    ram_stream_reader dut (
        .CLK       (clk),
        .RST       (rst),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .rd_addr   (rd_addr),
        .ram_q     (ram_q),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 256; i++)
            mem[i] = 8'(i);
    end

    always @(posedge clk) ram_q <= mem[rd_addr];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (done === 1'b1)
            done_cnt++;
    endtask

    // Runs the sink until done is seen, recording every word that transfers.
    task automatic collect(input bit toggle);
        bit         pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        bit         finished = 1'b0;
        logic       prev_v = 1'b0;
        logic       prev_r = 1'b0;
        logic [7:0] prev_d = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            out_ready = toggle ? pat[cyc % 5] : 1'b1;
            if (prev_v && !prev_r) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, prev_d);
            end
            if (out_valid && out_ready)
                got.push_back(out_data);
            prev_v = out_valid;
            prev_r = out_ready;
            prev_d = out_data;
            tick();
            if (done === 1'b1) begin
                finished = 1'b1;
                break;
            end
        end
        if (!finished)
            check("collect_timeout", 0, 1);
        out_ready = 1'b1;
    endtask

    initial begin
        logic [7:0] wrap_a [4] = '{8'd254, 8'd255, 8'd0, 8'd1};
        checks    = 0;
        errors    = 0;
        done_cnt  = 0;
        exp_done  = 0;
        rst       = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        length    = '0;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst_rd_addr", rd_addr, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b0;
        tick();

        // Basic burst: base 4, length 5, sink always ready.
        start = 1'b1; base_addr = 8'd4; length = 9'd5; out_ready = 1'b1;
        tick();
        start = 1'b0;
        check("b1_rd_e0", rd_addr, 4);
        check("b1_busy_e0", busy, 1);
        check("b1_valid_e0", out_valid, 0);
        tick();
        check("b1_rd_e1", rd_addr, 5);
        check("b1_valid_e1", out_valid, 0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("b1_valid", out_valid, 1);
            check("b1_data", out_data, 4 + k);
            check("b1_no_done", done, 0);
        end
        tick();
        exp_done++;
        check("b1_done", done, 1);
        check("b1_busy_done", busy, 0);
        check("b1_valid_end", out_valid, 0);
        check("b1_done_cnt", done_cnt, exp_done);
        tick();
        check("b1_done_once", done, 0);

        // Address wrap: base 254, length 4.
        start = 1'b1; base_addr = 8'd254; length = 9'd4;
        tick();
        start = 1'b0;
        check("wrap_rd", rd_addr, wrap_a[0]);
        for (int k = 1; k < 6; k++) begin
            tick();
            if (k < 4)
                check("wrap_rd", rd_addr, wrap_a[k]);
            if (k >= 2)
                check("wrap_data", out_data, wrap_a[k - 2]);
        end
        tick();
        exp_done++;
        check("wrap_done", done, 1);
        tick();

        // Back-pressure: length 10, ready pattern 1,0,0,1,0.
        got.delete();
        start = 1'b1; base_addr = 8'd20; length = 9'd10;
        tick();
        start = 1'b0;
        collect(1'b1);
        exp_done++;
        check("bp_count", got.size(), 10);
        for (int i = 0; i < got.size(); i++)
            check("bp_word", got[i], 20 + i);
        check("bp_done_cnt", done_cnt, exp_done);
        tick();
        check("bp_done_once", done, 0);

        // Empty burst: no reads, done the cycle after start.
        start = 1'b1; base_addr = 8'd77; length = 9'd0;
        tick();
        start = 1'b0;
        exp_done++;
        check("len0_done", done, 1);
        check("len0_busy", busy, 0);
        check("len0_valid", out_valid, 0);
        check("len0_rd", rd_addr, 29);
        tick();
        check("len0_done_once", done, 0);
        check("len0_rd_hold", rd_addr, 29);
        check("len0_busy2", busy, 0);

        // Reset three cycles into a length-8 burst aborts it.
        start = 1'b1; base_addr = 8'd40; length = 9'd8;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("abort_pre_data", out_data, 40);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_rd", rd_addr, 0);
        check("abort_valid", out_valid, 0);
        check("abort_data", out_data, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("abort_quiet", {out_valid, done, busy}, 0);
        end
        check("abort_done_cnt", done_cnt, exp_done);

        // Reset wins over a simultaneous start.
        rst = 1'b1; start = 1'b1; base_addr = 8'd5; length = 9'd3;
        tick();
        rst = 1'b0; start = 1'b0;
        check("rst_start_busy", busy, 0);
        check("rst_start_rd", rd_addr, 0);
        tick();
        check("rst_start_idle", busy, 0);

        // Fresh burst after the abort completes normally.
        start = 1'b1; base_addr = 8'd100; length = 9'd3;
        tick();
        start = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) begin
            tick();
            check("post_rst_data", out_data, 100 + k);
        end
        tick();
        exp_done++;
        check("post_rst_done", done, 1);
        tick();

        // Second start pulse mid-burst is ignored.
        start = 1'b1; base_addr = 8'd60; length = 9'd6;
        tick();
        start = 1'b0;
        check("restart_rd0", rd_addr, 60);
        tick();
        start = 1'b1; base_addr = 8'd0; length = 9'd2;
        tick();
        start = 1'b0;
        check("restart_rd2", rd_addr, 62);
        check("restart_data", out_data, 60);
        for (int k = 1; k < 6; k++) begin
            tick();
            check("restart_data", out_data, 60 + k);
        end
        tick();
        exp_done++;
        check("restart_done", done, 1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("restart_idle", {busy, done}, 0);
        end
        check("restart_done_cnt", done_cnt, exp_done);

        // Full address space: every address once, wrapping to base-1.
        got.delete();
        start = 1'b1; base_addr = 8'd7; length = 9'd256;
        tick();
        start = 1'b0;
        collect(1'b0);
        exp_done++;
        check("full_count", got.size(), 256);
        for (int i = 0; i < got.size(); i++)
            check("full_word", got[i], (7 + i) % 256);
        check("full_last_rd", rd_addr, 6);
        tick();
        check("full_done_cnt", done_cnt, exp_done);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_stream_reader.md
RAM_STREAM_READER -- requirements
Module: ram_stream_reader

Interface
REQ-001 Parameter ADDR_LEN, default 6, sets the address width: RAM address is ADDR_LEN+2 bits.
REQ-002 Parameter DATA_LEN, default 8, is the word width.
REQ-003 CLK  input  1  sole clock; all state updates on posedge CLK.
REQ-004 RST  input  1  reset; synchronous, active-high.
REQ-005 start  input  1  one-cycle request to begin a burst; sampled only in IDLE.
REQ-006 base_addr  input  ADDR_LEN+2  first RAM address of the burst; sampled with start.
REQ-007 length  input  ADDR_LEN+3  word count, 0..2^(ADDR_LEN+2); sampled with start.
REQ-008 rd_addr  output  ADDR_LEN+2  read address to the RAM.
REQ-009 ram_q  input  DATA_LEN  RAM read data; valid on the cycle after the posedge at which the RAM sampled rd_addr.
REQ-010 out_data  output  DATA_LEN  streamed word.
REQ-011 out_valid  output  1  out_data holds a valid word.
REQ-012 out_ready  input  1  sink accepts; transfer occurs on a posedge with out_valid && out_ready.
REQ-013 busy  output  1  burst in progress.
REQ-014 done  output  1  one-cycle pulse at burst completion.

Function
REQ-015 State machine SHALL have states IDLE, FETCH, DRAIN, DONE.
REQ-016 IDLE: on start=1 with length>0, latch base_addr/length, go FETCH; with length=0, go DONE with no reads; start=0 stays IDLE.
REQ-017 start SHALL be ignored in every state other than IDLE.
REQ-018 FETCH: issue one read per cycle while credit allows, rd_addr incrementing by 1 per issued read, modulo 2^(ADDR_LEN+2) (wrap from all-ones to 0).
REQ-019 When not issuing, rd_addr SHALL hold its last value; any resulting RAM output is discarded.
REQ-020 Credit rule: a read SHALL be issued only if (buffered words + reads in flight, both pipeline stages) < 3, after counting a transfer on the same edge; the output buffer is 3 entries deep.
REQ-021 Each returning ram_q word SHALL be captured into the output buffer exactly two posedges after its rd_addr was set; no word is ever dropped or duplicated.
REQ-022 Words SHALL leave in address order; out_data/out_valid are driven from the buffer head register.
REQ-023 out_data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-024 FETCH -> DRAIN once length reads have been issued; DRAIN -> DONE on the transfer of the last word.
REQ-025 DONE: done=1 for exactly one cycle, busy=0; then IDLE unconditionally.
REQ-026 busy SHALL be 1 in FETCH and DRAIN only.
REQ-027 Latency: start sampled at edge E0 -> rd_addr=base_addr after E0 -> out_valid=1 after E2; with out_ready held 1, one word per cycle, last transfer at E(length+2), done high in the cycle after it.
REQ-028 length = 2^(ADDR_LEN+2) SHALL read every address exactly once, wrapping to base_addr-1.
REQ-029 Simultaneous buffer capture and transfer on one edge SHALL keep occupancy unchanged.

Reset
REQ-030 RST=1 at a posedge SHALL force IDLE, rd_addr=0, out_data=0, out_valid=0, busy=0, done=0, buffer empty, in-flight count 0.
REQ-031 RST during FETCH/DRAIN SHALL abort the burst: no done pulse; RAM data returning after reset is discarded.
REQ-032 RST overrides start on the same edge.

Verification
REQ-033 RAM preloaded mem[i]=i; start, base_addr=4, length=5, out_ready=1 -> out_data 4,5,6,7,8 on consecutive cycles, first out_valid after E2, done one cycle after fifth transfer.
REQ-034 base_addr=254, length=4 (ADDR_LEN=6) -> rd_addr 254,255,0,1; out_data mem[254],mem[255],mem[0],mem[1].
REQ-035 length=10, out_ready toggled 1,0,0,1,0 repeating -> all 10 words in order, none lost/duplicated, out_data stable while stalled, buffer never exceeds 3.
REQ-036 length=0 -> no rd_addr change, out_valid stays 0, done pulse the cycle after start, busy never 1.
REQ-037 RST asserted 3 cycles into a length=8 burst -> outputs at reset values next cycle, no done; new start then completes normally with correct data.
REQ-038 start pulsed again mid-burst -> ignored; original burst completes with single done.
